// File: rtl/gate_test_pkg.sv
// Shared definitions for the gate test sequencer.
//   state_e     : sequencer FSM states
//   OP_*        : encodings of the expected gate function (GATE_OP)
//   TMR_W       : settle counter width
//   gate_expect : golden output of a 2-input gate for a given op and {a,b}
package gate_test_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic [1:0] OP_AND  = 2'd0;
  localparam logic [1:0] OP_OR   = 2'd1;
  localparam logic [1:0] OP_XOR  = 2'd2;
  localparam logic [1:0] OP_NAND = 2'd3;

  localparam int TMR_W = 8;

  // ab[1] is input A, ab[0] is input B.
  function automatic logic gate_expect(input logic [1:0] op, input logic [1:0] ab);
    logic r;
    case (op)
      OP_AND:  r = ab[1] & ab[0];
      OP_OR:   r = ab[1] | ab[0];
      OP_XOR:  r = ab[1] ^ ab[0];
      default: r = ~(ab[1] & ab[0]);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gate_test_sequencer_settle_timer.sv
// settle_timer: loadable down-counter with a zero flag.
//   clk, rst_n : clock, async active-low reset (count clears to 0)
//   load       : load load_val (wins over enable)
//   load_val   : value to load
//   en         : decrement by one; holds at zero
//   zero       : count == 0
module settle_timer
  import gate_test_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   cnt <= '0;
    else if (load)                cnt <= load_val;
    else if (en && (cnt != '0))   cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/gate_test_sequencer.sv
// gate_test_sequencer: drives the four input vectors 00,01,10,11 into a
// 2-input gate, holds each for SETTLE_CYCLES cycles, samples the gate output
// and compares it with the GATE_OP function.
//   clk, rst_n  : clock, async active-low reset
//   start       : run request, honoured only in IDLE
//   abort       : cancel a run in SETTLE/SAMPLE
//   dut_c       : gate-under-test output
//   a, b        : gate inputs (registered)
//   busy        : not in IDLE
//   done        : one-cycle pulse while in DONE
//   pass        : last completed run had no mismatches
//   err_cnt     : mismatch count, 0..4
//   first_fail  : {a,b} of the first mismatching vector (0 when none)
// Every output is a flop; dut_c only reaches next-state logic.
module gate_test_sequencer
  import gate_test_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int GATE_OP       = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       dut_c,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [1:0] first_fail
);

  localparam logic [1:0]       OP       = GATE_OP[1:0];
  localparam logic [TMR_W-1:0] LOAD_VAL = TMR_W'(SETTLE_CYCLES - 1);

  state_e     state, state_nx;
  logic [1:0] ab_q, ab_nx;
  logic [2:0] err_q, err_nx;
  logic [1:0] ff_q, ff_nx;
  logic       pass_q, pass_nx;
  logic       done_q, done_nx;
  logic       busy_q;
  logic       tmr_load, tmr_en, tmr_zero;

  settle_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (LOAD_VAL),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      ab_q   <= 2'b00;
      err_q  <= 3'd0;
      ff_q   <= 2'b00;
      pass_q <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nx;
      ab_q   <= ab_nx;
      err_q  <= err_nx;
      ff_q   <= ff_nx;
      pass_q <= pass_nx;
      done_q <= done_nx;
      // busy is registered from the next state so it stays a pure flop output
      busy_q <= (state_nx != ST_IDLE);
    end
  end

  always_comb begin
    state_nx = state;
    ab_nx    = ab_q;
    err_nx   = err_q;
    ff_nx    = ff_q;
    pass_nx  = pass_q;
    done_nx  = 1'b0;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          err_nx   = 3'd0;
          ff_nx    = 2'b00;
          ab_nx    = 2'b00;
          tmr_load = 1'b1;
          state_nx = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          ab_nx    = 2'b00;
          state_nx = ST_IDLE;
        end else if (tmr_zero) begin
          state_nx = ST_SAMPLE;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_SAMPLE: begin
        // abort wins: the mismatch of this cycle is discarded
        if (abort) begin
          ab_nx    = 2'b00;
          state_nx = ST_IDLE;
        end else begin
          if (dut_c != gate_expect(OP, ab_q)) begin
            if (err_q < 3'd4)  err_nx = err_q + 3'd1;
            if (err_q == 3'd0) ff_nx  = ab_q;
          end
          if (ab_q == 2'b11) begin
            // pass/done land together so pass is valid during the done pulse
            ab_nx    = 2'b00;
            pass_nx  = (err_nx == 3'd0);
            done_nx  = 1'b1;
            state_nx = ST_DONE;
          end else begin
            ab_nx    = ab_q + 2'b01;
            tmr_load = 1'b1;
            state_nx = ST_SETTLE;
          end
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  assign a          = ab_q[1];
  assign b          = ab_q[0];
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_cnt    = err_q;
  assign first_fail = ff_q;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Bench for gate_test_sequencer. Three instances share clk/rst_n:
//   u0: SETTLE=4, AND   u1: SETTLE=2, AND   u2: SETTLE=1, NAND
// Each instance's gate model is selected per test: ideal gate with a fault
// mask per vector, stuck-at-1, or AND with a 3-flop propagation delay.
module tb_gate_test_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] start = '0, abort = '0, dut_c;
  logic [2:0] a, b, busy, done, pass;
  logic [2:0] err_cnt [3];
  logic [1:0] first_fail [3];

  int         mode [3] = '{0, 0, 0};          // 0 masked ideal, 1 stuck-1, 2 delayed AND
  logic [3:0] mask [3] = '{4'h0, 4'h0, 4'h0}; // bit {a,b} set -> output inverted
  logic [2:0] dly  [3] = '{3'b0, 3'b0, 3'b0};

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  gate_test_sequencer #(.SETTLE_CYCLES(4), .GATE_OP(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]), .dut_c(dut_c[0]),
    .a(a[0]), .b(b[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .err_cnt(err_cnt[0]), .first_fail(first_fail[0]));
  gate_test_sequencer #(.SETTLE_CYCLES(2), .GATE_OP(0)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]), .dut_c(dut_c[1]),
    .a(a[1]), .b(b[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .err_cnt(err_cnt[1]), .first_fail(first_fail[1]));
  gate_test_sequencer #(.SETTLE_CYCLES(1), .GATE_OP(3)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .abort(abort[2]), .dut_c(dut_c[2]),
    .a(a[2]), .b(b[2]), .busy(busy[2]), .done(done[2]), .pass(pass[2]),
    .err_cnt(err_cnt[2]), .first_fail(first_fail[2]));

  function automatic int settle_of(input int i);
    return (i == 0) ? 4 : (i == 1) ? 2 : 1;
  endfunction

  function automatic logic ref_gate(input int i, input logic x, input logic y);
    return (i == 2) ? ~(x & y) : (x & y);
  endfunction

  always_comb begin
    dut_c = '0;
    for (int i = 0; i < 3; i++) begin
      case (mode[i])
        0:       dut_c[i] = ref_gate(i, a[i], b[i]) ^ mask[i][{a[i], b[i]}];
        1:       dut_c[i] = 1'b1;
        default: dut_c[i] = dly[i][2];
      endcase
    end
  end

  always @(posedge clk)
    for (int i = 0; i < 3; i++) dly[i] <= {dly[i][1:0], a[i] & b[i]};

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Start a run on instance i from a negedge (cycle 1) and check the done
  // pulse cycle, the result registers and the return to idle.
  task automatic do_run(input int i, input int exp_err, input int exp_ff, input string tag);
    int seen = 0;
    int lat  = 1 + 4 * (settle_of(i) + 1) + 1;
    start[i] = 1'b1;
    for (int c = 2; c <= 200; c++) begin
      @(negedge clk);
      if (c == 2) begin
        start[i] = 1'b0;
        chk({tag, ".busy"}, busy[i], 1);
      end
      if (done[i]) begin
        seen = c;
        break;
      end
    end
    if (seen == 0) chk({tag, ".timeout"}, 0, 1);
    else begin
      chk({tag, ".lat"}, seen, lat);
      chk({tag, ".err"}, err_cnt[i], exp_err);
      chk({tag, ".ff"}, first_fail[i], exp_ff);
      @(negedge clk);
      chk({tag, ".done_once"}, done[i], 0);
      chk({tag, ".idle"}, busy[i], 0);
      chk({tag, ".pass"}, pass[i], exp_err == 0);
      chk({tag, ".ab0"}, {a[i], b[i]}, 0);
    end
  endtask

  initial begin
    int d1, d2, early, ndone, e, f;
    logic [3:0] m;
    int i;

    // reset state
    #12;
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.pass", pass, 0);
    chk("rst.ab", {a, b}, 0);
    chk("rst.err", err_cnt[0], 0);
    chk("rst.ff", first_fail[0], 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // correct AND, then abort in the vector-01 settle with pass=1 held
    do_run(0, 0, 0, "and_ok");
    start[0] = 1'b1;
    for (int c = 2; c <= 8; c++) begin
      @(negedge clk);
      if (c == 2) start[0] = 1'b0;
      if (c == 7) begin
        chk("abort.vec01", {a[0], b[0]}, 1);
        abort[0] = 1'b1;
      end
      if (c == 8) begin
        abort[0] = 1'b0;
        chk("abort.busy", busy[0], 0);
        chk("abort.ab", {a[0], b[0]}, 0);
        chk("abort.done", done[0], 0);
        chk("abort.pass", pass[0], 1);
      end
    end
    ndone = 0;
    repeat (30) begin
      @(negedge clk);
      if (done[0]) ndone++;
    end
    chk("abort.nodone", ndone, 0);

    // stuck-at-1 against AND
    mode[0] = 1;
    do_run(0, 3, 0, "stuck1");

    // slow AND: missed at SETTLE=2, caught at SETTLE=4
    mode[1] = 2;
    do_run(1, 1, 3, "slow_s2");
    mode[0] = 2;
    do_run(0, 0, 0, "slow_s4");

    // random fault masks on the AND and NAND instances
    for (int n = 0; n < 8; n++) begin
      i = ($urandom_range(0, 1) == 0) ? 0 : 2;
      m = 4'($urandom_range(0, 15));
      mode[i] = 0;
      mask[i] = m;
      e = 0; f = -1;
      for (int v = 0; v < 4; v++)
        if (m[v]) begin
          e++;
          if (f < 0) f = v;
        end
      if (f < 0) f = 0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_run(i, e, f, $sformatf("rnd%0d_u%0d", n, i));
    end

    // start held for 50 cycles: back-to-back runs
    mode[0] = 0; mask[0] = 4'h0;
    d1 = 0; d2 = 0; early = 0;
    start[0] = 1'b1;
    for (int c = 2; c <= 90; c++) begin
      @(negedge clk);
      if (c == 51) start[0] = 1'b0;
      if (done[0]) begin
        if (c <= 50) early++;
        if (d1 == 0) d1 = c;
        else if (d2 == 0) d2 = c;
      end
    end
    chk("b2b.first", d1, 22);
    chk("b2b.second", d2, 44);
    chk("b2b.count", early, 2);
    chk("b2b.idle", busy[0], 0);

    // async reset in the SAMPLE of vector 10
    mode[0] = 1;
    start[0] = 1'b1;
    for (int c = 2; c <= 16; c++) begin
      @(negedge clk);
      if (c == 2) start[0] = 1'b0;
    end
    chk("midrst.pre_a", a[0], 1);
    chk("midrst.pre_err", err_cnt[0], 2);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst.busy", busy[0], 0);
    chk("midrst.ab", {a[0], b[0]}, 0);
    chk("midrst.err", err_cnt[0], 0);
    chk("midrst.ff", first_fail[0], 0);
    chk("midrst.pass_done", {pass[0], done[0]}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    mode[0] = 0;
    do_run(0, 0, 0, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gate_test_sequencer.md
GATE_TEST_SEQUENCER -- requirements
Module: gate_test_sequencer

Interface
REQ-001 The module SHALL have parameter SETTLE_CYCLES, default 4, meaning cycles each input vector is held before sampling; legal range 1..255.
REQ-002 The module SHALL have parameter GATE_OP, default 0, meaning the expected function of the gate under test: 0=AND, 1=OR, 2=XOR, 3=NAND.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 start  input  1  level-sampled run request; honoured only in IDLE.
REQ-006 abort  input  1  synchronous abort of a run in progress.
REQ-007 dut_c  input  1  output of the 2-input gate under test.
REQ-008 a  output  1  gate input A, registered.
REQ-009 b  output  1  gate input B, registered.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse at the end of a completed run.
REQ-012 pass  output  1  high when the last completed run had zero mismatches.
REQ-013 err_cnt  output  3  mismatch count of the current or last run, 0..4.
REQ-014 first_fail  output  2  index {a,b} of the first mismatching vector; 0 when none.

Function
REQ-015 The FSM SHALL have the states IDLE, SETTLE, SAMPLE and DONE.
REQ-016 In IDLE with start=1, the next edge SHALL clear err_cnt and first_fail, drive {a,b}=2'b00, load the settle counter with SETTLE_CYCLES-1 and enter SETTLE.
REQ-017 In SETTLE, the counter SHALL decrement each cycle, and the FSM SHALL enter SAMPLE on the edge where the counter is 0, so each vector is held stable for exactly SETTLE_CYCLES cycles before SAMPLE.
REQ-018 In SAMPLE, the FSM SHALL compare dut_c against the GATE_OP function of the current {a,b}.
REQ-019 On a mismatch in SAMPLE, err_cnt SHALL increment, and first_fail SHALL capture the current {a,b} if err_cnt was 0.
REQ-020 After SAMPLE, if {a,b}!=2'b11, the FSM SHALL drive {a,b}+1, reload the counter with SETTLE_CYCLES-1 and return to SETTLE.
REQ-021 After SAMPLE, if {a,b}==2'b11, the FSM SHALL enter DONE.
REQ-022 The vector sequence SHALL be 00, 01, 10, 11; the vector index SHALL never wrap within a run.
REQ-023 In DONE, done SHALL be 1 for exactly one cycle, pass SHALL be updated to (err_cnt==0), {a,b} SHALL return to 00, and the next state SHALL be IDLE.
REQ-024 A single run SHALL last 1+4*(SETTLE_CYCLES+1)+1 cycles from the start edge to the IDLE return; with default parameters this is 22 cycles.
REQ-025 start asserted while busy=1 SHALL be ignored.
REQ-026 start held high continuously SHALL launch a new run on the cycle after DONE.
REQ-027 abort=1 in SETTLE or SAMPLE SHALL force IDLE on the next edge with {a,b}=00 and done=0; pass, err_cnt and first_fail keep their values.
REQ-028 abort=1 in IDLE or DONE SHALL have no effect.
REQ-029 abort SHALL take priority over a mismatch update in the same cycle.
REQ-030 err_cnt SHALL saturate at 4, which is its maximum by construction.
REQ-031 err_cnt and first_fail SHALL remain readable and unchanged while in IDLE.

Reset
REQ-032 On rst_n=0, the module SHALL asynchronously enter IDLE with a=0, b=0, busy=0, done=0, pass=0, err_cnt=0, first_fail=0 and settle counter=0.
REQ-033 Reset asserted mid-run SHALL abandon the run immediately, without a done pulse.
REQ-034 Reset release SHALL take effect on the next rising edge of clk.

Structure
REQ-035 Package gate_test_pkg SHALL hold the FSM state enum, the GATE_OP encodings and a function that returns the expected output for a given op and {a,b}.
REQ-036 The settle counter SHALL be a sub-module settle_timer with ports load, load value, enable, zero flag, clk and rst_n; its width SHALL be 8 bits.
REQ-037 All outputs SHALL be driven directly from flops, with no combinational path from dut_c to any output.

Verification
REQ-038 The bench SHALL cover: GATE_OP=0, correct AND model, start pulse -> done at cycle 22, pass=1, err_cnt=0, first_fail=0.
REQ-039 The bench SHALL cover: GATE_OP=0, model stuck at 1 -> err_cnt=3, first_fail=2'b00, pass=0.
REQ-040 The bench SHALL cover: an AND model with 3-cycle propagation delay and SETTLE_CYCLES=2 -> the late 10->11 rise is missed, so err_cnt=1, first_fail=2'b11; the same model with SETTLE_CYCLES=4 -> pass=1.
REQ-041 The bench SHALL cover: abort in the second SETTLE (vector 01) -> IDLE next cycle, a=b=0, no done pulse, and pass unchanged from the previous run.
REQ-042 The bench SHALL cover: start held high for 50 cycles with default parameters -> two back-to-back runs, done pulses at cycles 22 and 44, start ignored while busy.
REQ-043 The bench SHALL cover: rst_n dropped mid-SAMPLE -> all outputs zero immediately, with no clock edge required.
